// File: rtl/wordle_pkg.sv
// rtl/wordle_pkg.sv - shared constants, colour codes, FSM states and letter helper
// Purpose: common definitions for the Wordle scorer and its letter matcher.
package wordle_pkg;

  localparam int ROWS = 6;  // guess rows in the grid
  localparam int COLS = 5;  // letters per word
  localparam int LW   = 8;  // bits per letter (ASCII)

  localparam logic [1:0] COL_EMPTY  = 2'b00;
  localparam logic [1:0] COL_GRAY   = 2'b01;
  localparam logic [1:0] COL_YELLOW = 2'b10;
  localparam logic [1:0] COL_GREEN  = 2'b11;

  typedef logic [LW-1:0] letter_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Letter 0 is the leftmost letter, held in the most significant byte.
  function automatic letter_t letter_at(input logic [COLS*LW-1:0] w, input int i);
    return w[(COLS-1-i)*LW +: LW];
  endfunction

endpackage

// File: rtl/wordle_letter_match.sv
// rtl/wordle_letter_match.sv - find lowest unused answer position holding a letter
// Purpose: combinational yellow-pass matcher.
// Ports: letter_i (guess letter), answer_i (answer letters), used_i (consumed
//        answer positions), hit_o (any match), match_oh_o (one-hot, lowest wins).
module wordle_letter_match
  import wordle_pkg::*;
(
  input  letter_t          letter_i,
  input  letter_t          answer_i [COLS],
  input  logic [COLS-1:0]  used_i,
  output logic             hit_o,
  output logic [COLS-1:0]  match_oh_o
);

  logic [COLS-1:0] cand;

  always_comb begin
    cand = '0;
    for (int j = 0; j < COLS; j++) begin
      cand[j] = !used_i[j] && (answer_i[j] == letter_i);
    end
  end

  assign hit_o      = |cand;
  // Isolate the lowest set bit so the leftmost free answer letter is consumed.
  assign match_oh_o = cand & (~cand + 1'b1);

endmodule

// File: rtl/wordle_scorer.sv
// rtl/wordle_scorer.sv - Wordle guess scorer with 6x5 tile colour grid
// Purpose: scores a committed guess (green pass, then yellow pass) and writes
//          the row of colours into the grid; renderer reads tiles combinationally.
// Ports: Clk, reset (async, active-high); Start/Clear commands; guess/answer/row
//        operands; Busy/Done/Win/Err status; rd_row/rd_col -> rd_color read port.
module wordle_scorer
  import wordle_pkg::*;
(
  input  logic               Clk,
  input  logic               reset,
  input  logic               Start,
  input  logic               Clear,
  input  logic [COLS*LW-1:0] guess,
  input  logic [COLS*LW-1:0] answer,
  input  logic [2:0]         row,
  output logic               Busy,
  output logic               Done,
  output logic               Win,
  output logic               Err,
  input  logic [2:0]         rd_row,
  input  logic [2:0]         rd_col,
  output logic [1:0]         rd_color
);

  state_t                        state_q;
  letter_t                       guess_q  [COLS];
  letter_t                       answer_q [COLS];
  logic [2:0]                    row_q;
  logic [2:0]                    idx_q;
  logic [COLS-1:0]               green_q;
  logic [COLS-1:0]               used_q;
  logic [1:0]                    color_q  [COLS];
  logic [ROWS*COLS-1:0][1:0]     grid_q;
  logic                          busy_q, done_q, win_q, err_q;

  logic                          hit;
  logic [COLS-1:0]               match_oh;

  wordle_letter_match u_match (
    .letter_i   (guess_q[idx_q]),
    .answer_i   (answer_q),
    .used_i     (used_q),
    .hit_o      (hit),
    .match_oh_o (match_oh)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      green_q <= '0;
      used_q  <= '0;
      grid_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        guess_q[i]  <= '0;
        answer_q[i] <= '0;
        color_q[i]  <= COL_EMPTY;
      end
    end else begin
      done_q <= 1'b0;
      if (Clear) begin
        // Clear beats Start and aborts any scoring in flight.
        state_q <= S_IDLE;
        grid_q  <= '0;
        busy_q  <= 1'b0;
        win_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (Start) begin
              for (int i = 0; i < COLS; i++) begin
                guess_q[i]  <= letter_at(guess, i);
                answer_q[i] <= letter_at(answer, i);
              end
              row_q   <= row;
              green_q <= '0;
              used_q  <= '0;
              win_q   <= 1'b0;
              err_q   <= 1'b0;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_GREEN;
            end
          end
          S_GREEN: begin
            // The latched row is validated on the first green cycle.
            if (idx_q == 3'd0 && row_q >= 3'(ROWS)) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              if (guess_q[idx_q] == answer_q[idx_q]) begin
                green_q[idx_q] <= 1'b1;
                used_q[idx_q]  <= 1'b1;
              end
              if (idx_q == 3'(COLS-1)) begin
                idx_q   <= '0;
                state_q <= S_YELLOW;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
          S_YELLOW: begin
            if (green_q[idx_q]) begin
              color_q[idx_q] <= COL_GREEN;
            end else if (hit) begin
              color_q[idx_q] <= COL_YELLOW;
              used_q         <= used_q | match_oh;
            end else begin
              color_q[idx_q] <= COL_GRAY;
            end
            if (idx_q == 3'(COLS-1)) begin
              state_q <= S_WRITE;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          S_WRITE: begin
            for (int c = 0; c < COLS; c++) begin
              grid_q[{2'b00, row_q} * 5'(COLS) + 5'(c)] <= color_q[c];
            end
            win_q   <= &green_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Win  = win_q;
  assign Err  = err_q;

  // Linear index only used when in range, so 5 bits suffice (max 29).
  logic [4:0] rd_lin;
  assign rd_lin   = {2'b00, rd_row} * 5'(COLS) + {2'b00, rd_col};
  assign rd_color = (rd_row < 3'(ROWS) && rd_col < 3'(COLS)) ? grid_q[rd_lin] : COL_EMPTY;

endmodule
